// File: rtl/rx_word_assembler_if.sv
// Word-assembler bus: serial bit input, frame control, and the word
// ready/ack handshake toward the EPC write port.
interface rx_word_assembler_if #(
  parameter int WORD_W = 16
);
  logic              rx_start;
  logic              rx_bit;
  logic              rx_bit_valid;
  logic [7:0]        rx_words;
  logic              word_ack;
  logic [WORD_W-1:0] data_word;
  logic              word_ready;
  logic [5:0]        word_index;
  logic              rx_done;
  logic              crc_ok;
  logic              overrun;
  logic              busy;

  modport master (
    output rx_start, rx_bit, rx_bit_valid, rx_words, word_ack,
    input  data_word, word_ready, word_index, rx_done, crc_ok, overrun, busy
  );

  modport slave (
    input  rx_start, rx_bit, rx_bit_valid, rx_words, word_ack,
    output data_word, word_ready, word_index, rx_done, crc_ok, overrun, busy
  );
endinterface

// File: rtl/rx_word_assembler.sv
// Deserializes an MSB-first bit stream into data words, presents them on a
// ready/ack handshake and checks the trailing Gen2 CRC-16 residue.
module rx_word_assembler #(
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 32
) (
  input logic              data_clk,
  input logic              reset,
  rx_word_assembler_if.slave bus
);
  localparam int N_W = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  state_t            state_r;
  logic [N_W-1:0]    n_words_r;
  logic [N_W-1:0]    words_rcvd_r;
  logic [3:0]        bit_cnt_r;
  logic [WORD_W-1:0] sreg_r;
  logic [15:0]       crc_r;
  logic [WORD_W-1:0] data_word_r;
  logic              word_ready_r;
  logic [5:0]        word_index_r;
  logic              rx_done_r;
  logic              crc_ok_r;
  logic              overrun_r;
  logic              busy_r;

  logic [15:0]       crc_next_s;
  logic [N_W-1:0]    n_words_s;
  logic              ack_s;
  logic              word_done_s;

  // Next CRC value, saturated word count and handshake/word-completion strobes
  always_comb begin
    crc_next_s = crc16_step(crc_r, bus.rx_bit);
    if (bus.rx_words > 8'(MAX_WORDS)) begin
      n_words_s = N_W'(MAX_WORDS);
    end else begin
      n_words_s = bus.rx_words[N_W-1:0];
    end
    ack_s       = bus.word_ack && word_ready_r;
    word_done_s = (state_r == DATA) && bus.rx_bit_valid && (bit_cnt_r == 4'(WORD_W - 1));
  end

  // Frame FSM with registered outputs; rx_start overrides everything but reset
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      n_words_r    <= '0;
      words_rcvd_r <= '0;
      bit_cnt_r    <= 4'd0;
      sreg_r       <= '0;
      crc_r        <= CRC_INIT;
      data_word_r  <= '0;
      word_ready_r <= 1'b0;
      word_index_r <= 6'd0;
      rx_done_r    <= 1'b0;
      crc_ok_r     <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else if (bus.rx_start) begin
      n_words_r    <= n_words_s;
      words_rcvd_r <= '0;
      bit_cnt_r    <= 4'd0;
      sreg_r       <= '0;
      crc_r        <= CRC_INIT;
      word_ready_r <= 1'b0;
      word_index_r <= 6'd0;
      rx_done_r    <= 1'b0;
      crc_ok_r     <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b1;
      state_r      <= (n_words_s != '0) ? DATA : CRC;
    end else begin
      if (ack_s) begin
        word_ready_r <= 1'b0;
        word_index_r <= word_index_r + 6'd1;
      end
      case (state_r)
        DATA: begin
          if (bus.rx_bit_valid) begin
            crc_r     <= crc_next_s;
            sreg_r    <= {sreg_r[WORD_W-2:0], bus.rx_bit};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            // A completing word wins over a same-cycle ack clearing word_ready
            if (word_done_s) begin
              data_word_r  <= {sreg_r[WORD_W-2:0], bus.rx_bit};
              word_ready_r <= 1'b1;
              if (word_ready_r && !bus.word_ack) begin
                overrun_r <= 1'b1;
              end
              words_rcvd_r <= words_rcvd_r + N_W'(1);
              if ((words_rcvd_r + N_W'(1)) == n_words_r) begin
                state_r <= CRC;
              end
            end
          end
        end
        CRC: begin
          if (bus.rx_bit_valid) begin
            crc_r     <= crc_next_s;
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd15) begin
              state_r   <= DONE;
              busy_r    <= 1'b0;
              rx_done_r <= 1'b1;
              crc_ok_r  <= (crc_next_s == CRC_RESIDUE);
            end
          end
        end
        IDLE, DONE: begin
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_word  = data_word_r;
  assign bus.word_ready = word_ready_r;
  assign bus.word_index = word_index_r;
  assign bus.rx_done    = rx_done_r;
  assign bus.crc_ok     = crc_ok_r;
  assign bus.overrun    = overrun_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_rx_word_assembler.sv
// Self-checking bench for rx_word_assembler: vector table, hand-written corner
// sequences and randomized frames against an event-level reference model.
module tb_rx_word_assembler;
  logic data_clk = 1'b0;
  logic reset;

  rx_word_assembler_if #(.WORD_W(16)) bus ();

  rx_word_assembler #(.WORD_W(16), .MAX_WORDS(32)) dut (
    .data_clk (data_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 data_clk = ~data_clk;

  typedef struct {
    int          rxw;
    logic [15:0] w0, w1, w2;
    int          flip;
    int          mode;
    logic [15:0] e_word;
    int          e_index;
    logic        e_ok;
    logic        e_ovr;
  } vec_t;

  vec_t        tbl [4];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] fw    [0:31];
  logic        fbits [0:599];
  logic        exp_ready, exp_ovr, exp_ok;
  logic [15:0] exp_word;
  logic [5:0]  exp_index;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock: apply inputs, let the edge sample them, observe 1 time unit later
  task automatic cyc(input logic start, input logic [7:0] rxw, input logic valid,
                     input logic b, input logic ack);
    bus.rx_start     = start;
    bus.rx_words     = rxw;
    bus.rx_bit_valid = valid;
    bus.rx_bit       = b;
    bus.word_ack     = ack;
    @(posedge data_clk);
    #1;
    bus.rx_start     = 1'b0;
    bus.rx_bit_valid = 1'b0;
    bus.word_ack     = 1'b0;
  endtask

  function automatic logic [15:0] crc_over(input int nbits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < nbits; i++) begin
      if (c[15] ^ fbits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                  c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // mode: 0 ack promptly, 1 never ack, 2 ack only on a word completion, 3 random
  task automatic run_frame(input int rxw, input int flip, input int mode, input bit gaps);
    int nw, total, fl, i;
    logic [15:0] c;
    logic valid, ack, done_w;
    logic [7:0] rxw8;
    nw    = (rxw > 32) ? 32 : rxw;
    rxw8  = 8'(rxw);
    total = 0;
    for (int k = 0; k < nw; k++)
      for (int j = 15; j >= 0; j--) begin
        fbits[total] = fw[k][j];
        total++;
      end
    c = ~crc_over(total);
    for (int j = 15; j >= 0; j--) begin
      fbits[total] = c[j];
      total++;
    end
    fl = flip;
    if (flip == -2) fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
    if (fl >= 0) fbits[fl] = ~fbits[fl];
    exp_ok = (fl < 0);

    cyc(1'b1, rxw8, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    exp_ready = 1'b0;
    exp_index = 6'd0;
    exp_ovr   = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_ready", bus.word_ready, 0);
    chk("start_index", bus.word_index, 0);
    chk("start_done", bus.rx_done, 0);

    i = 0;
    while (i < total) begin
      valid  = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      done_w = valid && (i < nw * 16) && (i % 16 == 15);
      case (mode)
        0:       ack = exp_ready;
        1:       ack = 1'b0;
        2:       ack = done_w && exp_ready;
        default: ack = 1'($urandom_range(0, 1));
      endcase
      cyc(1'b0, 8'd0, valid, fbits[i], ack);
      if (ack && exp_ready) exp_index++;
      if (done_w) begin
        if (exp_ready && !ack) exp_ovr = 1'b1;
        exp_ready = 1'b1;
        exp_word  = fw[i / 16];
      end else if (ack) begin
        exp_ready = 1'b0;
      end
      if (valid) i++;
      chk("word_ready", bus.word_ready, exp_ready);
      chk("word_index", bus.word_index, exp_index);
      chk("overrun", bus.overrun, exp_ovr);
      if (exp_ready) chk("data_word", bus.data_word, exp_word);
      chk("busy", bus.busy, i < total);
      chk("rx_done", bus.rx_done, i == total);
    end
    chk("crc_ok", bus.crc_ok, exp_ok);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 8'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk("done_hold", bus.rx_done, 1);
      chk("crc_ok_hold", bus.crc_ok, exp_ok);
      chk("busy_done", bus.busy, 0);
      chk("ready_hold", bus.word_ready, exp_ready);
    end
  endtask

  initial begin
    tbl[0] = '{1, 16'hA5C3, 16'h0000, 16'h0000, -1, 0, 16'hA5C3, 1, 1'b1, 1'b0};
    tbl[1] = '{3, 16'h3000, 16'h1234, 16'hFFFF, 49, 0, 16'hFFFF, 3, 1'b0, 1'b0};
    tbl[2] = '{2, 16'h1111, 16'h2222, 16'h0000, -1, 1, 16'h2222, 0, 1'b1, 1'b1};
    tbl[3] = '{2, 16'hABCD, 16'h5678, 16'h0000, -1, 2, 16'h5678, 1, 1'b1, 1'b0};

    reset            = 1'b1;
    bus.rx_start     = 1'b0;
    bus.rx_bit       = 1'b0;
    bus.rx_bit_valid = 1'b0;
    bus.rx_words     = 8'd0;
    bus.word_ack     = 1'b0;
    repeat (2) @(posedge data_clk);
    #1;
    chk("rst_data", bus.data_word, 0);
    chk("rst_ready", bus.word_ready, 0);
    chk("rst_index", bus.word_index, 0);
    chk("rst_done", bus.rx_done, 0);
    chk("rst_crc_ok", bus.crc_ok, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;

    for (int k = 0; k < 20; k++) cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("idle_ready", bus.word_ready, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_data", bus.data_word, 0);
    chk("idle_done", bus.rx_done, 0);

    for (int r = 0; r < 4; r++) begin
      fw[0] = tbl[r].w0;
      fw[1] = tbl[r].w1;
      fw[2] = tbl[r].w2;
      run_frame(tbl[r].rxw, tbl[r].flip, tbl[r].mode, 1'b0);
      chk("tbl_word", bus.data_word, tbl[r].e_word);
      chk("tbl_index", bus.word_index, tbl[r].e_index);
      chk("tbl_crc_ok", bus.crc_ok, tbl[r].e_ok);
      chk("tbl_overrun", bus.overrun, tbl[r].e_ovr);
      if (tbl[r].mode == 1) begin
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("late_ack_index", bus.word_index, 1);
        chk("late_ack_ready", bus.word_ready, 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("idle_ack_index", bus.word_index, 1);
      end
    end

    // Abort a frame after 7 bits of ones, then a clean frame must not see them
    cyc(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("abort_busy", bus.busy, 1);
    fw[0] = 16'h0F0F;
    run_frame(1, -1, 0, 1'b0);
    chk("restart_word", bus.data_word, 16'h0F0F);
    chk("restart_ok", bus.crc_ok, 1);

    run_frame(0, -1, 0, 1'b0);
    chk("zero_ok", bus.crc_ok, 1);
    chk("zero_ready", bus.word_ready, 0);

    for (int k = 0; k < 32; k++) fw[k] = 16'($urandom);
    run_frame(40, -1, 0, 1'b0);
    chk("sat_index", bus.word_index, 32);
    chk("sat_word", bus.data_word, fw[31]);

    // Asynchronous reset while in the CRC state
    fw[0] = 16'h5A5A;
    cyc(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int j = 15; j >= 0; j--) cyc(1'b0, 8'd0, 1'b1, fw[0][j], 1'b0);
    chk("pre_rst_ready", bus.word_ready, 1);
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_data", bus.data_word, 0);
    chk("arst_ready", bus.word_ready, 0);
    chk("arst_index", bus.word_index, 0);
    chk("arst_done", bus.rx_done, 0);
    chk("arst_crc_ok", bus.crc_ok, 0);
    chk("arst_overrun", bus.overrun, 0);
    chk("arst_busy", bus.busy, 0);
    @(posedge data_clk);
    #1 reset = 1'b0;

    for (int f = 0; f < 20; f++) begin
      int rxw;
      rxw = int'($urandom_range(0, 5));
      for (int k = 0; k < 5; k++) fw[k] = 16'($urandom);
      run_frame(rxw, -2, 3, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
